ex_mem_pipe: RTL

- EX/MEM pipeline register of the 5-stage MIPS core; sits between the execute stage and the MEM stage, directly upstream of the MEM/WB control register.
- Latches datapath values (PC, instruction, ALU result, store data, destination register) and control (regw, memw, memtoreg, jjal, T_new), and ages T_new by one stage.
- Produces the MEM-stage forwarding value and a forward-valid qualifier for the hazard unit.
- Supports stall-hold and bubble insertion.

---
 rtl/ex_mem_pipe.sv | 81 ++++++++
 1 files changed

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX/MEM pipeline register with T_new aging, stall-hold, bubble flush
// and the MEM-stage forwarding value/qualifier for the hazard unit.
module ex_mem_pipe #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int TNEW_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  input  logic [31:0]       instr_E,
  input  logic [31:0]       pc_E,
  input  logic [31:0]       alu_out_E,
  input  logic [31:0]       rt_data_E,
  input  logic [4:0]        a3_E,
  input  logic              regw_E,
  input  logic              memw_E,
  input  logic              memtoreg_E,
  input  logic              jjal_E,
  input  logic [TNEW_W-1:0] T_new_E,
  output logic [31:0]       instr_M,
  output logic [31:0]       pc_M,
  output logic [31:0]       alu_out_M,
  output logic [31:0]       rt_data_M,
  output logic [4:0]        a3_M,
  output logic              regw_M,
  output logic              memw_M,
  output logic              memtoreg_M,
  output logic              jjal_M,
  output logic [TNEW_W-1:0] T_new_M,
  output logic [31:0]       pc8_M,
  output logic [31:0]       fwd_data_M,
  output logic              fwd_valid_M
);
  logic [31:0]       r_instr, r_pc, r_alu, r_rt;
  logic [4:0]        r_a3;
  logic              r_regw, r_memw, r_memtoreg, r_jjal;
  logic [TNEW_W-1:0] r_tnew;
  logic [31:0]       w_pc8;
  // A bubble looks exactly like the reset state so it can never write back.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_instr    <= '0;
      r_pc       <= RESET_PC;
      r_alu      <= '0;
      r_rt       <= '0;
      r_a3       <= '0;
      r_regw     <= 1'b0;
      r_memw     <= 1'b0;
      r_memtoreg <= 1'b0;
      r_jjal     <= 1'b0;
      r_tnew     <= '0;
    end else if (en) begin
      r_instr    <= instr_E;
      r_pc       <= pc_E;
      r_alu      <= alu_out_E;
      r_rt       <= rt_data_E;
      r_a3       <= a3_E;
      r_regw     <= regw_E;
      r_memw     <= memw_E;
      r_memtoreg <= memtoreg_E;
      r_jjal     <= jjal_E;
      r_tnew     <= (T_new_E != '0) ? T_new_E - TNEW_W'(1) : '0;
    end
  end
  assign w_pc8       = r_pc + 32'd8;
  assign instr_M     = r_instr;
  assign pc_M        = r_pc;
  assign alu_out_M   = r_alu;
  assign rt_data_M   = r_rt;
  assign a3_M        = r_a3;
  assign regw_M      = r_regw;
  assign memw_M      = r_memw;
  assign memtoreg_M  = r_memtoreg;
  assign jjal_M      = r_jjal;
  assign T_new_M     = r_tnew;
  assign pc8_M       = w_pc8;
  assign fwd_data_M  = r_jjal ? w_pc8 : r_alu;
  // Loads are never forwarded from here; $0 is never a forwarding target.
  assign fwd_valid_M = r_regw & (r_a3 != 5'd0) & (r_tnew == '0) & ~r_memtoreg;
endmodule
